// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, key one-hots and decoder types for the PS/2 key tracker.
package keyboard_pkg;

   localparam int unsigned NUM_KEYS = 6;

   // Set-2 scan codes of interest
   localparam logic [7:0] ARROW_UP    = 8'h75;
   localparam logic [7:0] ARROW_DOWN  = 8'h72;
   localparam logic [7:0] ARROW_LEFT  = 8'h6B;
   localparam logic [7:0] ARROW_RIGHT = 8'h74;
   localparam logic [7:0] ENTER       = 8'h5A;
   localparam logic [7:0] ESC         = 8'h76;
   localparam logic [7:0] PFX_EXT     = 8'hE0;
   localparam logic [7:0] PFX_BRK     = 8'hF0;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

   localparam key_vec_t KEY_NONE  = 6'b000000;
   localparam key_vec_t KEY_UP    = 6'b000001;
   localparam key_vec_t KEY_DOWN  = 6'b000010;
   localparam key_vec_t KEY_LEFT  = 6'b000100;
   localparam key_vec_t KEY_RIGHT = 6'b001000;
   localparam key_vec_t KEY_ENTER = 6'b010000;
   localparam key_vec_t KEY_ESC   = 6'b100000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } decode_state_t;

   // One decoded make/break event for the key-state logic
   typedef struct packed {
      logic     make;
      logic     brk;
      logic     ext;
      key_vec_t key;
   } key_event_t;

   // Maps a completed scan code to its one-hot key; unknown codes give KEY_NONE
   function automatic key_vec_t map_code(input logic [7:0] code,
                                         input logic       ext,
                                         input logic       keypad);
      key_vec_t k;
      k = KEY_NONE;
      if (ext || keypad) begin
         case (code)
            ARROW_UP:    k = KEY_UP;
            ARROW_DOWN:  k = KEY_DOWN;
            ARROW_LEFT:  k = KEY_LEFT;
            ARROW_RIGHT: k = KEY_RIGHT;
            default:     k = KEY_NONE;
         endcase
      end
      if (!ext) begin
         case (code)
            ENTER:   k = KEY_ENTER;
            ESC:     k = KEY_ESC;
            default: ;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat down-counter: loads the initial delay or the repeat period,
// flags expiry combinationally in the last counted cycle.
module key_repeat_timer
   import keyboard_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 20_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_delay,
   input  logic load_period,
   input  logic stop,
   output logic expire_c
);

   localparam int unsigned MAX_LOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CW       = $clog2(MAX_LOAD) + 1;

   logic [CW-1:0] cnt;

   // Counter: stop beats loads, loads beat counting, zero means idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (stop) begin
         cnt <= '0;
      end else if (load_delay) begin
         cnt <= CW'(REPEAT_DELAY);
      end else if (load_period) begin
         cnt <= CW'(REPEAT_PERIOD);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Expiry lands so the owner's registered pulse appears exactly on the count boundary
   assign expire_c = (cnt == CW'(1));

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: tracks held game keys and emits press/release pulses with auto-repeat.
module ps2_key_tracker
   import keyboard_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY   = 20_000_000,
   parameter int unsigned REPEAT_PERIOD  = 5_000_000,
   parameter int unsigned PREFIX_TIMEOUT = 100_000,
   parameter int unsigned ACCEPT_KEYPAD  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          code,
   input  logic                code_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   localparam int unsigned TW        = $clog2(PREFIX_TIMEOUT) + 1;
   localparam logic        KEYPAD_EN = (ACCEPT_KEYPAD != 0);

   decode_state_t state, state_nxt;
   key_event_t    evt_c;
   logic [TW-1:0] tmo_cnt;
   key_vec_t      target;

   logic new_press_c;
   logic release_c;
   logic target_rel_c;
   logic fire_c;
   logic expire_c;

   // Decode state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and event decode; a byte arriving on the timeout cycle is decoded normally
   always_comb begin
      state_nxt = state;
      evt_c     = '0;
      if (code_valid) begin
         unique case (state)
            ST_IDLE: begin
               if (code == PFX_EXT) begin
                  state_nxt = ST_EXT;
               end else if (code == PFX_BRK) begin
                  state_nxt = ST_BRK;
               end else begin
                  evt_c.make = 1'b1;
               end
            end
            ST_EXT: begin
               if (code == PFX_BRK) begin
                  state_nxt = ST_EXT_BRK;
               end else if (code != PFX_EXT) begin
                  evt_c.make = 1'b1;
                  evt_c.ext  = 1'b1;
                  state_nxt  = ST_IDLE;
               end
            end
            ST_BRK: begin
               evt_c.brk = 1'b1;
               state_nxt = ST_IDLE;
            end
            ST_EXT_BRK: begin
               evt_c.brk = 1'b1;
               evt_c.ext = 1'b1;
               state_nxt = ST_IDLE;
            end
         endcase
      end else if ((state != ST_IDLE) && (tmo_cnt == TW'(1))) begin
         state_nxt = ST_IDLE;
      end
      evt_c.key = map_code(code, evt_c.ext, KEYPAD_EN);
   end

   // Prefix timeout: reloaded by every byte, counts down to zero and holds
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if (code_valid) begin
         tmo_cnt <= TW'(PREFIX_TIMEOUT);
      end else if (tmo_cnt != '0) begin
         tmo_cnt <= tmo_cnt - TW'(1);
      end
   end

   // Key-state decisions; new press and target release both pre-empt a repeat expiry
   assign new_press_c  = evt_c.make && (evt_c.key != KEY_NONE) && ((evt_c.key & key_held) == KEY_NONE);
   assign release_c    = evt_c.brk && ((evt_c.key & key_held) != KEY_NONE);
   assign target_rel_c = release_c && (evt_c.key == target);
   assign fire_c       = expire_c && (target != KEY_NONE) && !new_press_c && !target_rel_c;

   key_repeat_timer #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_repeat (
      .clk         (clk),
      .rst         (rst),
      .load_delay  (new_press_c),
      .load_period (fire_c),
      .stop        (target_rel_c),
      .expire_c    (expire_c)
   );

   // Held bitmap, pulse outputs and repeat target
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_held    <= KEY_NONE;
         key_press   <= KEY_NONE;
         key_release <= KEY_NONE;
         target      <= KEY_NONE;
      end else begin
         key_press   <= KEY_NONE;
         key_release <= KEY_NONE;
         if (new_press_c) begin
            key_held  <= key_held | evt_c.key;
            key_press <= evt_c.key;
            target    <= evt_c.key;
         end else if (release_c) begin
            key_held    <= key_held & ~evt_c.key;
            key_release <= evt_c.key;
            if (target_rel_c) begin
               target <= KEY_NONE;
            end
         end
         if (fire_c) begin
            key_press <= target;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: keypad-enabled and keypad-disabled trackers fed the same byte stream.
module tb_ps2_key_tracker;

   localparam int unsigned DELAY  = 10;
   localparam int unsigned PERIOD = 4;
   localparam int unsigned TMO    = 8;

   logic       clk;
   logic       rst;
   logic [7:0] code;
   logic       code_valid;
   logic [5:0] key_held, key_press, key_release;
   logic [5:0] nk_held, nk_press, nk_release;

   int     vectors    = 0;
   int     miscompares = 0;
   longint ecount     = 0;

   // Reference model state, index 0 = keypad accepted, 1 = keypad ignored
   logic [5:0] m_held[2];
   bit         m_ext[2];
   bit         m_brk[2];
   int         m_idle[2];
   int         m_tgt[2];
   longint     m_next[2];
   logic [5:0] exp_held[2];
   logic [5:0] exp_press[2];
   logic [5:0] exp_rel[2];

   ps2_key_tracker #(
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .PREFIX_TIMEOUT(TMO), .ACCEPT_KEYPAD(1)
   ) dut (
      .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
      .key_held(key_held), .key_press(key_press), .key_release(key_release)
   );

   ps2_key_tracker #(
      .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .PREFIX_TIMEOUT(TMO), .ACCEPT_KEYPAD(0)
   ) dut_nk (
      .clk(clk), .rst(rst), .code(code), .code_valid(code_valid),
      .key_held(nk_held), .key_press(nk_press), .key_release(nk_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int key_idx(input logic [7:0] c, input bit ext, input bit keypad);
      if (ext || keypad) begin
         if (c == 8'h75) return 0;
         if (c == 8'h72) return 1;
         if (c == 8'h6B) return 2;
         if (c == 8'h74) return 3;
      end
      if (!ext) begin
         if (c == 8'h5A) return 4;
         if (c == 8'h76) return 5;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_held[k] = '0; m_ext[k] = 0; m_brk[k] = 0; m_idle[k] = 0;
         m_tgt[k] = -1; m_next[k] = -1;
         exp_held[k] = '0; exp_press[k] = '0; exp_rel[k] = '0;
      end
   endtask

   // One clock edge of the key-tracking rules, in absolute edge time
   task automatic model_step(input logic v, input logic [7:0] c);
      ecount++;
      for (int k = 0; k < 2; k++) begin
         bit is_make, is_brk, ext, newp;
         int idx;
         is_make = 0; is_brk = 0; ext = 0; newp = 0; idx = -1;
         exp_press[k] = '0; exp_rel[k] = '0;
         if (v) begin
            m_idle[k] = 0;
            if (!m_ext[k] && !m_brk[k]) begin
               if (c == 8'hE0) m_ext[k] = 1;
               else if (c == 8'hF0) m_brk[k] = 1;
               else is_make = 1;
            end else if (m_ext[k] && !m_brk[k]) begin
               if (c == 8'hF0) m_brk[k] = 1;
               else if (c != 8'hE0) begin is_make = 1; ext = 1; m_ext[k] = 0; end
            end else begin
               is_brk = 1; ext = m_ext[k]; m_ext[k] = 0; m_brk[k] = 0;
            end
         end else if (m_ext[k] || m_brk[k]) begin
            m_idle[k]++;
            if (m_idle[k] >= int'(TMO)) begin m_ext[k] = 0; m_brk[k] = 0; end
         end
         if (is_make || is_brk) idx = key_idx(c, ext, k == 0);
         if (is_make && idx >= 0 && !m_held[k][idx]) begin
            m_held[k][idx] = 1'b1; exp_press[k][idx] = 1'b1;
            m_tgt[k] = idx; m_next[k] = ecount + DELAY; newp = 1;
         end
         if (is_brk && idx >= 0 && m_held[k][idx]) begin
            m_held[k][idx] = 1'b0; exp_rel[k][idx] = 1'b1;
            if (m_tgt[k] == idx) m_tgt[k] = -1;
         end
         if (!newp && m_tgt[k] >= 0 && m_next[k] == ecount) begin
            exp_press[k][m_tgt[k]] = 1'b1;
            m_next[k] = ecount + PERIOD;
         end
         exp_held[k] = m_held[k];
      end
   endtask

   function automatic logic [35:0] dut_vec();
      return {key_held, key_press, key_release, nk_held, nk_press, nk_release};
   endfunction

   function automatic logic [35:0] model_vec();
      return {exp_held[0], exp_press[0], exp_rel[0], exp_held[1], exp_press[1], exp_rel[1]};
   endfunction

   // Drive one byte (or idle) for one cycle; returns at the following negedge
   task automatic step(input logic v, input logic [7:0] c);
      code_valid = v;
      code       = c;
      @(posedge clk);
      model_step(v, c);
      @(negedge clk);
   endtask

   task automatic do_reset();
      code_valid = 1'b0;
      rst        = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   function automatic logic [7:0] rand_code();
      logic [7:0] tbl [12];
      tbl = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76, 8'hE1, 8'hAA, 8'hFA, 8'hFE};
      if ($urandom_range(0, 9) == 0) return 8'($urandom);
      return tbl[$urandom_range(0, 11)];
   endfunction

   task automatic test_reset();
      rst = 1'b0; code_valid = 1'b0; code = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if ({key_held, key_press, key_release} !== 18'h0) begin
         miscompares++;
         $display("FAIL reset_kp: got %h required 0", {key_held, key_press, key_release});
      end
      vectors++;
      if ({nk_held, nk_press, nk_release} !== 18'h0) begin
         miscompares++;
         $display("FAIL reset_nk: got %h required 0", {nk_held, nk_press, nk_release});
      end
      rst = 1'b1;
      model_reset();
      step(1'b0, 8'h00);
      vectors++;
      if (dut_vec() !== model_vec()) begin
         miscompares++;
         $display("FAIL reset_idle: got %h required %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_ext_arrow();
      do_reset();
      step(1'b1, 8'hE0);
      step(1'b1, 8'h75);
      vectors++;
      if (key_held !== 6'b000001 || key_press !== 6'b000001 || nk_press !== 6'b000001) begin
         miscompares++;
         $display("FAIL ext_make: held=%b press=%b nk_press=%b required 000001", key_held, key_press, nk_press);
      end
      step(1'b0, 8'h00);
      vectors++;
      if (key_press !== 6'b000000 || key_held !== 6'b000001) begin
         miscompares++;
         $display("FAIL ext_single_pulse: press=%b held=%b required 000000/000001", key_press, key_held);
      end
      step(1'b1, 8'hE0);
      step(1'b1, 8'hF0);
      step(1'b1, 8'h75);
      vectors++;
      if (key_held !== 6'b000000 || key_release !== 6'b000001) begin
         miscompares++;
         $display("FAIL ext_break: held=%b release=%b required 000000/000001", key_held, key_release);
      end
   endtask

   task automatic test_typematic();
      int pulses;
      pulses = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h5A);
         if (key_press === 6'b010000) pulses++;
         vectors++;
         if (key_held !== 6'b010000) begin
            miscompares++;
            $display("FAIL typematic_held: got %b required 010000", key_held);
         end
         step(1'b0, 8'h00);
         if (key_press === 6'b010000) pulses++;
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL typematic_pulses: got %0d required 1", pulses);
      end
      step(1'b1, 8'hF0);
      step(1'b1, 8'h5A);
      vectors++;
      if (key_held !== 6'b000000 || key_release !== 6'b010000) begin
         miscompares++;
         $display("FAIL typematic_break: held=%b release=%b required 000000/010000", key_held, key_release);
      end
   endtask

   task automatic test_repeat();
      logic [30:0] got_mask, exp_mask;
      bit          stray;
      got_mask = '0; exp_mask = '0; stray = 0;
      exp_mask[0] = 1'b1; exp_mask[10] = 1'b1; exp_mask[14] = 1'b1; exp_mask[18] = 1'b1;
      do_reset();
      step(1'b1, 8'hE0);
      step(1'b1, 8'h6B);
      got_mask[0] = key_press[2];
      for (int i = 1; i <= 30; i++) begin
         if (i == 18)      step(1'b1, 8'hE0);
         else if (i == 19) step(1'b1, 8'hF0);
         else if (i == 20) step(1'b1, 8'h6B);
         else              step(1'b0, 8'h00);
         got_mask[i] = key_press[2];
         if ((key_press & 6'b111011) != 6'b000000) stray = 1;
      end
      vectors++;
      if (got_mask !== exp_mask || stray) begin
         miscompares++;
         $display("FAIL repeat_timing: got %b required %b stray=%0d", got_mask, exp_mask, stray);
      end
   endtask

   task automatic test_retarget();
      logic [5:0] exp_p;
      do_reset();
      step(1'b1, 8'hE0);
      step(1'b1, 8'h6B);
      for (int i = 1; i <= 5; i++) begin
         if (i == 4)      step(1'b1, 8'hE0);
         else if (i == 5) step(1'b1, 8'h74);
         else             step(1'b0, 8'h00);
      end
      vectors++;
      if (key_press !== 6'b001000) begin
         miscompares++;
         $display("FAIL retarget_press: got %b required 001000", key_press);
      end
      for (int j = 1; j <= 12; j++) begin
         step(1'b0, 8'h00);
         exp_p = (j == 10) ? 6'b001000 : 6'b000000;
         vectors++;
         if (key_press !== exp_p || key_held !== 6'b001100) begin
            miscompares++;
            $display("FAIL retarget_%0d: press=%b held=%b required %b/001100", j, key_press, key_held, exp_p);
         end
      end
   endtask

   task automatic test_prefix_timeout();
      int gaps [3];
      bit ext_expected;
      gaps = '{7, 8, 9};
      for (int g = 0; g < 3; g++) begin
         do_reset();
         ext_expected = (gaps[g] < int'(TMO));
         step(1'b1, 8'hE0);
         for (int i = 0; i < gaps[g]; i++) step(1'b0, 8'h00);
         step(1'b1, 8'h75);
         vectors++;
         if (key_press !== 6'b000001) begin
            miscompares++;
            $display("FAIL timeout_kp_gap%0d: press=%b required 000001", gaps[g], key_press);
         end
         vectors++;
         if (nk_press !== (ext_expected ? 6'b000001 : 6'b000000) ||
             nk_held  !== (ext_expected ? 6'b000001 : 6'b000000)) begin
            miscompares++;
            $display("FAIL timeout_nk_gap%0d: press=%b held=%b required %0d", gaps[g], nk_press, nk_held, ext_expected);
         end
      end
   endtask

   task automatic test_priority();
      logic [5:0] exp_p, exp_r, exp_h;
      do_reset();
      step(1'b1, 8'hE0);
      step(1'b1, 8'h6B);
      for (int i = 1; i <= 24; i++) begin
         if (i == 9 || i == 18) step(1'b1, 8'hE0);
         else if (i == 19)      step(1'b1, 8'hF0);
         else if (i == 10 || i == 20) step(1'b1, 8'h75);
         else                   step(1'b0, 8'h00);
         exp_p = (i == 10) ? 6'b000001 : 6'b000000;
         exp_r = (i == 20) ? 6'b000001 : 6'b000000;
         exp_h = (i >= 10 && i < 20) ? 6'b000101 : 6'b000100;
         vectors++;
         if (key_press !== exp_p || key_release !== exp_r || key_held !== exp_h) begin
            miscompares++;
            $display("FAIL priority_%0d: press=%b rel=%b held=%b required %b/%b/%b",
                     i, key_press, key_release, key_held, exp_p, exp_r, exp_h);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 8'hE0);
      step(1'b1, 8'h74);
      step(1'b1, 8'hE0);
      step(1'b1, 8'hF0);
      vectors++;
      if (key_held !== 6'b001000) begin
         miscompares++;
         $display("FAIL midreset_pre: held=%b required 001000", key_held);
      end
      code_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (dut_vec() !== 36'h0) begin
         miscompares++;
         $display("FAIL midreset_async: got %h required 0", dut_vec());
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 8'h74);
      vectors++;
      if (key_press !== 6'b001000 || key_held !== 6'b001000 || key_release !== 6'b000000 ||
          nk_held !== 6'b000000 || nk_release !== 6'b000000) begin
         miscompares++;
         $display("FAIL midreset_after: press=%b held=%b rel=%b nk_held=%b required 001000/001000/000000/000000",
                  key_press, key_held, key_release, nk_held);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(1'b1, rand_code());
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL b2b edge=%0d: got %h required %h", ecount, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) step(1'b1, rand_code());
         else                           step(1'b0, 8'($urandom));
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL random edge=%0d: got %h required %h", ecount, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b0; code_valid = 1'b0; code = 8'h00;
      model_reset();
      test_reset();
      test_ext_arrow();
      test_typematic();
      test_repeat();
      test_retarget();
      test_prefix_timeout();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
